compare_win: RTL and testbench
==============================

COMPARE_WIN -- requirements
Module: compare_win

Interface
REQ-001 Parameter WIDTH, default 8, comparison and threshold width in bits; SHALL be >= 2.
REQ-002 Parameter FILT, default 4, consecutive qualifying cycles required before out changes; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 nRst  input  1  reset; asynchronous, active-low.
REQ-005 set  input  1  config write strobe, sampled on the rising edge.
REQ-006 set_sel  input  2  write target: 0 = lo threshold, 1 = hi threshold, 2 = mode, 3 = soft clear.
REQ-007 cmp_static  input  WIDTH  config write data; only bits [1:0] are used when set_sel = 2.
REQ-008 cmp  input  WIDTH  unsigned sample under test.
REQ-009 out  output  1  filtered, registered comparison result.
REQ-010 evt_rise  output  1  one-cycle pulse on the edge where out goes 0->1.
REQ-011 evt_fall  output  1  one-cycle pulse on the edge where out goes 1->0.

Function
REQ-012 Internal registers SHALL be: lo[WIDTH], hi[WIDTH], mode[2], raw_q[1], cnt[clog2(FILT)+1], out, evt_rise, evt_fall.
REQ-013 All comparisons SHALL be unsigned and full WIDTH, with no truncation.
REQ-014 The raw result SHALL be computed from cmp and the current (pre-edge) lo, hi and mode.
REQ-015 Mode 0 (LESS): raw = cmp < lo.
REQ-016 Mode 1 (GEQ): raw = cmp >= lo.
REQ-017 Mode 2 (WINDOW): raw = (cmp >= lo) and (cmp <= hi); if lo > hi, raw = 0.
REQ-018 Mode 3 (HYST): raw = 1 if cmp >= hi; raw = 0 if cmp < lo; otherwise raw = current out.
REQ-019 raw_q SHALL load raw on every edge.
REQ-020 Filter, evaluated each edge, case raw_q == out: cnt <= 0.
REQ-021 Filter, case raw_q != out and cnt == FILT-1: out <= raw_q, cnt <= 0, and the matching evt pulse is asserted.
REQ-022 Filter, case raw_q != out and cnt < FILT-1: cnt <= cnt+1.
REQ-023 Latency: cmp sampled at edge N and held SHALL change out at edge N+FILT; with FILT = 1, out changes at edge N+1.
REQ-024 A single disagreeing raw_q sample followed by an agreeing one SHALL return cnt to 0 (glitch rejection).
REQ-025 evt_rise and evt_fall SHALL be high for exactly one cycle and SHALL never be high together; both SHALL be 0 on all other edges.
REQ-026 set = 1 with set_sel 0, 1 or 2 SHALL write the selected register at that edge and force cnt <= 0; out SHALL be held.
REQ-027 A write per REQ-026 SHALL take priority over the filter update at the same edge.
REQ-028 New configuration SHALL take effect for the raw value sampled on the edge following the write.
REQ-029 set = 1 with set_sel = 3 SHALL force out <= 0 and cnt <= 0, with no evt_fall; lo, hi and mode SHALL be unchanged.
REQ-030 The cnt comparison SHALL not wrap: cnt SHALL never exceed FILT-1.
REQ-031 When set = 0, config registers SHALL hold their values.

Reset
REQ-032 While nRst = 0, and immediately on its assertion irrespective of clk: lo = 0, hi = all ones, mode = 0, raw_q = 0, cnt = 0, out = 0, evt_rise = 0, evt_fall = 0.
REQ-033 The reset defaults (LESS mode, lo = 0) SHALL hold out at 0 for every cmp until reconfigured.
REQ-034 Reset asserted mid-filter SHALL discard the partial count; the first edge after deassertion SHALL behave as normal operation.

Verification (WIDTH=8, FILT=4)
REQ-035 Reset defaults: after reset, sweep cmp 0x00..0xFF, one value per cycle -> out = 0 throughout, no evt pulses.
REQ-036 GEQ filter: mode=1, lo=0xAA; cmp steps 0x00 -> 0xAA and holds -> out rises exactly 4 edges after the sampling edge, evt_rise high for 1 cycle; cmp = 0xA9 for 3 cycles then 0xAA -> no change.
REQ-037 WINDOW: mode=2, lo=0x10, hi=0x20; cmp held at 0x0F, 0x10, 0x20, 0x21 for 8 cycles each -> out = 0, 1, 1, 0 respectively.
REQ-038 WINDOW inverted: mode=2, lo=0x30, hi=0x20; cmp held at 0x25 -> out = 0.
REQ-039 HYST: mode=3, lo=0x40, hi=0xC0; cmp ramps 0x00 -> 0xFF -> 0x00 -> out rises after cmp >= 0xC0 and falls after cmp < 0x40; cmp = 0x80 leaves out unchanged in both directions.
REQ-040 Config write and soft clear: a write 2 cycles into a pending transition restarts the count, so out changes 4 edges after the write; with out = 1, set_sel = 3 -> out = 0 on the next edge with no evt_fall; nRst pulsed mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/compare_win_if.sv
// Bus bundle for compare_win: config write port, sample input and
// filtered result / edge-event outputs.
interface compare_win_if #(
  parameter int WIDTH = 8
);
  logic             set;
  logic [1:0]       set_sel;
  logic [WIDTH-1:0] cmp_static;
  logic [WIDTH-1:0] cmp;
  logic             out;
  logic             evt_rise;
  logic             evt_fall;

  modport master (
    output set, set_sel, cmp_static, cmp,
    input  out, evt_rise, evt_fall
  );

  modport slave (
    input  set, set_sel, cmp_static, cmp,
    output out, evt_rise, evt_fall
  );
endinterface

// File: rtl/compare_win.sv
// Programmable comparator (less / geq / window / hysteresis) with a
// consecutive-sample debounce filter and one-cycle edge event pulses.
module compare_win #(
  parameter int WIDTH = 8,
  parameter int FILT  = 4
) (
  input  logic         clk,
  input  logic         nRst,
  compare_win_if.slave bus
);
  localparam int            CW      = $clog2(FILT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT - 1);

  localparam logic [1:0] M_LESS = 2'd0;
  localparam logic [1:0] M_GEQ  = 2'd1;
  localparam logic [1:0] M_WIN  = 2'd2;

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [1:0]       r_mode;
  logic             r_raw_q;
  logic [CW-1:0]    r_cnt;
  logic             r_out;
  logic             r_evt_rise;
  logic             r_evt_fall;

  logic w_raw;
  logic w_wr;
  logic w_clr;

  // Config writes (lo/hi/mode) and soft clear share the strobe; sel 3 is clear.
  assign w_wr  = bus.set && (bus.set_sel != 2'd3);
  assign w_clr = bus.set && (bus.set_sel == 2'd3);

  // Unfiltered comparison against the current thresholds; hysteresis
  // holds the present output while the sample sits between lo and hi.
  always_comb begin
    w_raw = 1'b0;
    case (r_mode)
      M_LESS:  w_raw = (bus.cmp < r_lo);
      M_GEQ:   w_raw = (bus.cmp >= r_lo);
      M_WIN:   w_raw = (r_lo <= r_hi) && (bus.cmp >= r_lo) && (bus.cmp <= r_hi);
      default: begin
        if (bus.cmp >= r_hi)     w_raw = 1'b1;
        else if (bus.cmp < r_lo) w_raw = 1'b0;
        else                     w_raw = r_out;
      end
    endcase
  end

  // Config registers, sample register and debounce filter; a write or
  // clear restarts the count and takes precedence over the filter.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_lo       <= '0;
      r_hi       <= '1;
      r_mode     <= M_LESS;
      r_raw_q    <= 1'b0;
      r_cnt      <= '0;
      r_out      <= 1'b0;
      r_evt_rise <= 1'b0;
      r_evt_fall <= 1'b0;
    end else begin
      r_raw_q    <= w_raw;
      r_evt_rise <= 1'b0;
      r_evt_fall <= 1'b0;
      if (w_wr) begin
        case (bus.set_sel)
          2'd0:    r_lo   <= bus.cmp_static;
          2'd1:    r_hi   <= bus.cmp_static;
          default: r_mode <= bus.cmp_static[1:0];
        endcase
        r_cnt <= '0;
      end else if (w_clr) begin
        r_out <= 1'b0;
        r_cnt <= '0;
      end else if (r_raw_q == r_out) begin
        r_cnt <= '0;
      end else if (r_cnt >= CNT_MAX) begin
        // Saturating compare keeps cnt from ever passing FILT-1.
        r_out      <= r_raw_q;
        r_cnt      <= '0;
        r_evt_rise <= r_raw_q;
        r_evt_fall <= ~r_raw_q;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.out      = r_out;
  assign bus.evt_rise = r_evt_rise;
  assign bus.evt_fall = r_evt_fall;
endmodule

// File: tb/tb_compare_win.sv
// Self-checking bench for compare_win (WIDTH=8, FILT=4): directed
// scenarios plus a randomized run against a streak-count reference model.
module tb_compare_win;
  localparam int FILT = 4;

  logic clk  = 1'b0;
  logic nRst = 1'b0;

  compare_win_if #(.WIDTH(8)) bus();

  compare_win #(.WIDTH(8), .FILT(FILT)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  string phase = "init";

  // reference state
  int m_lo, m_hi, m_mode, m_rawq, m_out, m_streak, m_rise, m_fall;
  int saw_rise, saw_fall;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  function automatic int spec_raw(input int c, input int lo, input int hi,
                                  input int mode, input int o);
    case (mode)
      0: return int'(c < lo);
      1: return int'(c >= lo);
      2: return int'(lo <= hi && c >= lo && c <= hi);
      default: begin
        if (c >= hi) return 1;
        if (c < lo)  return 0;
        return o;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_lo = 0; m_hi = 255; m_mode = 0; m_rawq = 0;
    m_out = 0; m_streak = 0; m_rise = 0; m_fall = 0;
  endtask

  // One clock edge of the reference: out flips after FILT consecutive
  // disagreeing samples; writes/clears restart the streak.
  task automatic model_edge(input logic s, input logic [1:0] sel,
                            input logic [7:0] d, input logic [7:0] c);
    int nr;
    nr = spec_raw(int'(c), m_lo, m_hi, m_mode, m_out);
    m_rise = 0; m_fall = 0;
    if (s && sel != 2'd3) begin
      if (sel == 2'd0)      m_lo = int'(d);
      else if (sel == 2'd1) m_hi = int'(d);
      else                  m_mode = int'(d) % 4;
      m_streak = 0;
    end else if (s) begin
      m_out = 0; m_streak = 0;
    end else if (m_rawq != m_out) begin
      m_streak++;
      if (m_streak == FILT) begin
        if (m_rawq == 1) m_rise = 1; else m_fall = 1;
        m_out = m_rawq; m_streak = 0;
      end
    end else begin
      m_streak = 0;
    end
    m_rawq = nr;
  endtask

  task automatic cycle(input logic s, input logic [1:0] sel,
                       input logic [7:0] d, input logic [7:0] c);
    bus.set = s; bus.set_sel = sel; bus.cmp_static = d; bus.cmp = c;
    model_edge(s, sel, d, c);
    @(posedge clk); #1;
    chk("out",      int'(bus.out),      m_out);
    chk("evt_rise", int'(bus.evt_rise), m_rise);
    chk("evt_fall", int'(bus.evt_fall), m_fall);
    chk("evt_excl", int'(bus.evt_rise & bus.evt_fall), 0);
    saw_rise += int'(bus.evt_rise);
    saw_fall += int'(bus.evt_fall);
  endtask

  task automatic hold(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 8'h00, c);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] d);
    cycle(1'b1, sel, d, bus.cmp);
  endtask

  initial begin
    int at;
    logic [7:0] v;
    bus.set = 1'b0; bus.set_sel = 2'd0; bus.cmp_static = 8'h00; bus.cmp = 8'h00;
    model_reset();
    saw_rise = 0; saw_fall = 0;

    // reset state while held in reset
    phase = "reset";
    #12;
    chk("out",      int'(bus.out), 0);
    chk("evt_rise", int'(bus.evt_rise), 0);
    chk("evt_fall", int'(bus.evt_fall), 0);
    @(negedge clk) nRst = 1'b1;

    // reset defaults: LESS with lo=0 never asserts
    phase = "defaults";
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      cycle(1'b0, 2'd0, 8'h00, v);
    end
    hold(8'h00, 6);
    chk("sweep_out", int'(bus.out), 0);
    chk("sweep_evts", saw_rise + saw_fall, 0);

    // GEQ latency and glitch rejection
    phase = "geq";
    wr(2'd2, 8'h01);
    wr(2'd0, 8'hAA);
    hold(8'h00, 6);
    saw_rise = 0;
    cycle(1'b0, 2'd0, 8'h00, 8'hAA);
    at = -1;
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b0, 2'd0, 8'h00, 8'hAA);
      if (bus.out && at < 0) at = k;
    end
    chk("latency", at, 4);
    chk("rise_pulses", saw_rise, 1);
    saw_fall = 0;
    hold(8'hA9, 3);
    hold(8'hAA, 8);
    chk("glitch_out", int'(bus.out), 1);
    chk("glitch_fall", saw_fall, 0);

    // WINDOW
    phase = "window";
    wr(2'd2, 8'h02);
    wr(2'd0, 8'h10);
    wr(2'd1, 8'h20);
    hold(8'h0F, 8); chk("w0F", int'(bus.out), 0);
    hold(8'h10, 8); chk("w10", int'(bus.out), 1);
    hold(8'h20, 8); chk("w20", int'(bus.out), 1);
    hold(8'h21, 8); chk("w21", int'(bus.out), 0);
    wr(2'd0, 8'h30);
    hold(8'h25, 8); chk("inverted", int'(bus.out), 0);

    // HYST ramp
    phase = "hyst";
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h40);
    wr(2'd1, 8'hC0);
    hold(8'h00, 6);
    at = -1;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      cycle(1'b0, 2'd0, 8'h00, v);
      if (bus.out && at < 0) at = i;
    end
    chk("rise_at", at, 8'hC4);
    at = -1;
    for (int i = 255; i >= 0; i--) begin
      v = 8'(i);
      cycle(1'b0, 2'd0, 8'h00, v);
      if (!bus.out && at < 0) at = i;
    end
    chk("fall_at", at, 8'h3B);
    hold(8'h80, 8); chk("mid_low", int'(bus.out), 0);
    hold(8'hFF, 8); chk("to_high", int'(bus.out), 1);
    hold(8'h80, 8); chk("mid_high", int'(bus.out), 1);

    // write restarts pending transition
    phase = "restart";
    hold(8'h00, 3);
    wr(2'd1, 8'hC0);
    at = -1;
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b0, 2'd0, 8'h00, 8'h00);
      if (!bus.out && at < 0) at = k;
    end
    chk("after_write", at, 4);

    // soft clear
    phase = "clear";
    hold(8'hFF, 8);
    chk("pre_clear", int'(bus.out), 1);
    saw_fall = 0;
    cycle(1'b1, 2'd3, 8'h00, 8'h80);
    chk("cleared", int'(bus.out), 0);
    chk("no_fall", saw_fall, 0);
    hold(8'h80, 8);
    chk("mid_after_clear", int'(bus.out), 0);
    hold(8'hFF, 8);
    chk("hyst_kept", int'(bus.out), 1);

    // async reset mid-count
    phase = "rst_mid";
    hold(8'h00, 2);
    #2 nRst = 1'b0;
    #1;
    chk("out",      int'(bus.out), 0);
    chk("evt_rise", int'(bus.evt_rise), 0);
    chk("evt_fall", int'(bus.evt_fall), 0);
    model_reset();
    @(negedge clk) nRst = 1'b1;
    hold(8'hFF, 8);
    chk("less_default", int'(bus.out), 0);

    // randomized run
    phase = "random";
    v = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        cycle(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), v);
      else begin
        if ($urandom_range(0, 7) == 0) v = 8'($urandom);
        cycle(1'b0, 2'd0, 8'h00, v);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
